// File: rtl/sr_latch_bank.sv
// rtl/sr_latch_bank.sv - bank of clocked SR storage channels with S=R=1 policy, input filter and conflict counter
module sr_latch_bank #(
    parameter int               WIDTH       = 8,
    parameter int               MODE        = 0,
    parameter int               FILTER      = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] conflict,
    output logic [15:0]      conflict_cnt
);

    localparam int         EFF_MODE = (MODE < 0 || MODE > 3) ? 2 : MODE;
    localparam int         FILT_I   = (FILTER < 0) ? 0 : ((FILTER > 255) ? 255 : FILTER);
    localparam logic [7:0] FILT     = FILT_I[7:0];

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] conf_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [1:0] sh;
        logic [1:0] pair;
        logic [7:0] cnt;
        logic       same;
        logic       applied;
        logic       qn;

        assign pair = {s[gi], r[gi]};
        assign same = (pair == sh);
        // cnt counts repeats after the first sighting, so cnt+1 preceding edges matched
        assign applied = (FILT == 8'd0) ||
                         (same && (({1'b0, cnt} + 9'd1) >= {1'b0, FILT}));

        always_comb begin
            qn = q[gi];
            if (en && applied) begin
                case (pair)
                    2'b10: qn = 1'b1;
                    2'b01: qn = 1'b0;
                    2'b11: begin
                        case (EFF_MODE)
                            0:       qn = 1'b0;
                            1:       qn = 1'b1;
                            3:       qn = ~q[gi];
                            default: qn = q[gi];
                        endcase
                    end
                    default: qn = q[gi];
                endcase
            end
        end

        assign q_d[gi]    = qn;
        assign conf_d[gi] = en && applied && (pair == 2'b11);

        // filter keeps tracking the inputs even while en is low
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sh  <= 2'b00;
                cnt <= 8'd0;
            end else if (!same) begin
                sh  <= pair;
                cnt <= 8'd0;
            end else if (cnt != FILT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q            <= RESET_VALUE;
            p            <= ~RESET_VALUE;
            conflict     <= '0;
            conflict_cnt <= 16'd0;
        end else begin
            q        <= q_d;
            p        <= ~q_d;
            conflict <= conf_d;
            if ((|conf_d) && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// tb/tb_sr_latch_bank.sv - randomized self-checking bench for sr_latch_bank against a run-length reference model
module tb_sr_latch_bank;

    localparam int NDUT = 6;
    localparam int W    = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;

    logic [W-1:0] q_o [NDUT];
    logic [W-1:0] p_o [NDUT];
    logic [W-1:0] c_o [NDUT];
    logic [15:0]  n_o [NDUT];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int mode_of(int k);
        case (k)
            1: return 1;
            2: return 2;
            3: return 3;
            5: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int filt_of(int k);
        case (k)
            4: return 3;
            5: return 1;
            default: return 0;
        endcase
    endfunction

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        sr_latch_bank #(
            .WIDTH(W), .MODE(mode_of(k)), .FILTER(filt_of(k)), .RESET_VALUE(RV)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r),
            .q(q_o[k]), .p(p_o[k]), .conflict(c_o[k]), .conflict_cnt(n_o[k])
        );
    end

    // reference: a pair is applied once it has been seen on FILTER+1 consecutive edges
    int         run  [NDUT][W];
    int         last [NDUT][W];
    logic [7:0] mq   [NDUT];
    logic [7:0] mconf[NDUT];
    int         mcnt [NDUT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            mq[k] = RV;
            mconf[k] = '0;
            mcnt[k] = 0;
            for (int c = 0; c < W; c++) begin
                run[k][c] = 0;
                last[k][c] = -1;
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            int m;
            m = mode_of(k);
            if (m > 3) m = 2;
            mconf[k] = '0;
            for (int c = 0; c < W; c++) begin
                int pr;
                pr = {30'd0, s[c], r[c]};
                if (pr == last[k][c]) begin
                    if (run[k][c] < 1000) run[k][c]++;
                end else begin
                    last[k][c] = pr;
                    run[k][c] = 1;
                end
                if (en && run[k][c] >= filt_of(k) + 1) begin
                    if (pr == 2) mq[k][c] = 1'b1;
                    else if (pr == 1) mq[k][c] = 1'b0;
                    else if (pr == 3) begin
                        mconf[k][c] = 1'b1;
                        if (m == 0) mq[k][c] = 1'b0;
                        else if (m == 1) mq[k][c] = 1'b1;
                        else if (m == 3) mq[k][c] = ~mq[k][c];
                    end
                end
            end
            if (mconf[k] != 0 && mcnt[k] < 65535) mcnt[k]++;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("q[%0d]", k), {24'd0, q_o[k]}, {24'd0, mq[k]});
            check($sformatf("p[%0d]", k), {24'd0, p_o[k]}, {24'd0, ~mq[k]});
            check($sformatf("conflict[%0d]", k), {24'd0, c_o[k]}, {24'd0, mconf[k]});
            check($sformatf("cnt[%0d]", k), {16'd0, n_o[k]}, mcnt[k]);
        end
    endtask

    task automatic step(input logic e, input logic [W-1:0] sv, input logic [W-1:0] rv);
        en = e;
        s  = sv;
        r  = rv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // assert reset between edges and check it takes effect without a clock
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            check("rst_q", {24'd0, q_o[k]}, 32'h0000_00A5);
            check("rst_p", {24'd0, p_o[k]}, 32'h0000_005A);
            check("rst_conf", {24'd0, c_o[k]}, 32'd0);
            check("rst_cnt", {16'd0, n_o[k]}, 32'd0);
        end
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] rs, rr;
        logic         re;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // basic set / reset / hold, then a mid-cycle reset
        step(1'b1, 8'h02, 8'h00);
        step(1'b1, 8'h01, 8'h00);
        check("basic_set", {31'd0, q_o[0][0]}, 32'd1);
        step(1'b1, 8'h00, 8'h01);
        check("basic_clr", {31'd0, q_o[0][0]}, 32'd0);
        step(1'b1, 8'h00, 8'h00);
        step(1'b1, 8'h00, 8'h00);
        pulse_reset();

        // S=R=1 policies on ch0, starting from Q[0]=0
        step(1'b1, 8'h00, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 8'h01);
        check("mode3_tog", {31'd0, q_o[3][0]}, 32'd1);
        check("mode_cnt", {16'd0, n_o[0]}, 32'd3);
        step(1'b1, 8'h00, 8'h00);

        // filter: a 3-edge pulse is rejected, a 4-edge pulse is taken
        pulse_reset();
        step(1'b1, 8'h00, 8'h01);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 8'h00);
        step(1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 8'h00);
        check("filt_take", {31'd0, q_o[4][0]}, 32'd1);

        // en gating with a long-stable pair
        for (int i = 0; i < 10; i++) step(1'b0, 8'h02, 8'h00);
        step(1'b1, 8'h02, 8'h00);
        check("en_first", {31'd0, q_o[4][1]}, 32'd1);

        // random traffic, with repeats so filtered pairs get through
        rs = '0; rr = '0; re = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                rs = W'($urandom) & W'($urandom);
                rr = W'($urandom) & W'($urandom);
            end
            if ($urandom_range(0, 9) < 2) re = ($urandom_range(0, 4) != 0);
            step(re, rs, rr);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        // counter saturation
        pulse_reset();
        for (int i = 0; i < 65540; i++) step(1'b1, 8'h01, 8'h01);
        check("sat", {16'd0, n_o[0]}, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 8'h01);
        step(1'b1, 8'h00, 8'h00);
        check("sat_hold", {16'd0, n_o[0]}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
